// File: rtl/weight_pkg.sv
// Shared types and constants for the fixed-weight pattern enumerator.
// Read by weight_enum and by the optional weight checker (WEIGHT_CHECK_EN).
package weight_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam int IDX_W = 14;
    localparam int MAX_W = 16;

    // Trailing-zero count of a one-hot (nonzero) value; returns MAX_W for zero.
    function automatic logic [4:0] trail_zeros(input logic [MAX_W-1:0] v);
        logic [4:0] n;
        n = 5'(MAX_W);
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (v[i]) n = 5'(i);
        end
        return n;
    endfunction

endpackage

// File: rtl/weight_enum_popcnt.sv
// 4-bit population count used by the optional weight checker.
// Compiled only when WEIGHT_CHECK_EN is defined.
`ifdef WEIGHT_CHECK_EN
module popcnt_4 (
    input  logic [3:0] din,
    output logic [2:0] cnt
);

    always_comb begin
        cnt = 3'(din[0]) + 3'(din[1]) + 3'(din[2]) + 3'(din[3]);
    end

endmodule
`endif

// File: rtl/weight_enum.sv
// Enumerates every W-bit pattern of Hamming weight k in increasing order, one per cycle.
// Optional macro WEIGHT_CHECK_EN adds a sticky chk_err output from a popcount checker.
module weight_enum
    import weight_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       k,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_pattern,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
    output logic             err
`ifdef WEIGHT_CHECK_EN
    ,
    output logic             chk_err
`endif
);

    state_e           state_q, state_d;
    logic [4:0]       k_q, k_d;
    logic [W-1:0]     pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;

    logic [W-1:0]     load_mask;
    logic [W-1:0]     top_mask;
    logic             last_c;
    logic [W-1:0]     low_bit;
    logic [W-1:0]     ripple;
    logic [4:0]       low_pos;
    logic [5:0]       shamt;
    logic [W-1:0]     succ;

    // Lowest-k ones for loading, highest-k ones for detecting the final pattern.
    always_comb begin
        load_mask = '0;
        top_mask  = '0;
        for (int i = 0; i < W; i++) begin
            load_mask[i] = (i < int'(k));
            top_mask[i]  = (i >= W - int'(k_q));
        end
    end

    assign last_c = (pat_q == top_mask);

    // Next larger value with the same number of ones (Gosper's step), W bits wide.
    always_comb begin
        low_bit = pat_q & (~pat_q + W'(1));
        ripple  = pat_q + low_bit;
        low_pos = trail_zeros(MAX_W'(low_bit));
        shamt   = 6'(low_pos) + 6'd2;
        succ    = ripple | ((pat_q ^ ripple) >> shamt);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (int'(k) > W) begin
                        err_d = 1'b1;
                    end else begin
                        k_d     = k;
                        pat_d   = load_mask;
                        idx_d   = '0;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_c) begin
                        state_d = IDLE;
                    end else begin
                        pat_d = succ;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            pat_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign out_valid   = (state_q == EMIT);
    assign busy        = (state_q == EMIT);
    assign out_pattern = pat_q;
    assign out_idx     = idx_q;
    assign out_last    = (state_q == EMIT) && last_c;
    assign err         = err_q;

`ifdef WEIGHT_CHECK_EN
    localparam int NNIB = W / 4;

    logic [2:0] nib_cnt [NNIB];
    logic [4:0] pop_c;
    logic       chk_err_q, chk_err_d;

    // The checker observes the output port so that it sees exactly what leaves the block.
    for (genvar g = 0; g < NNIB; g++) begin : g_pc
        popcnt_4 u_popcnt (
            .din (out_pattern[4*g +: 4]),
            .cnt (nib_cnt[g])
        );
    end

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < NNIB; i++) begin
            pop_c = pop_c + 5'(nib_cnt[i]);
        end
        chk_err_d = chk_err_q | (out_valid && (pop_c != k_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_weight_enum.sv
// Randomized self-checking bench for weight_enum (W=8) against a numeric-order reference list.
// Build with WEIGHT_CHECK_EN defined to also exercise the chk_err checker.
module tb_weight_enum;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  k_in = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [W-1:0] out_pattern;
    logic        out_last;
    logic [13:0] out_idx;
    logic        busy;
    logic        err;
`ifdef WEIGHT_CHECK_EN
    logic        chk_err;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    weight_enum #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .k           (k_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_pattern (out_pattern),
        .out_last    (out_last),
        .out_idx     (out_idx),
        .busy        (busy),
        .err         (err)
`ifdef WEIGHT_CHECK_EN
        ,
        .chk_err     (chk_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All W-bit values with kk ones, ascending: the required emission order.
    task automatic build_ref(input int kk, output logic [W-1:0] q[$]);
        logic [W-1:0] v;
        q = {};
        for (int i = 0; i < (1 << W); i++) begin
            v = i[W-1:0];
            if ($countones(v) == kk) q.push_back(v);
        end
    endtask

    task automatic check_idle_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_pat"},   32'(out_pattern), 0);
        chk({tag, "_last"},  32'(out_last), 0);
        chk({tag, "_idx"},   32'(out_idx), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_err"},   32'(err), 0);
    endtask

    // mode 0: ready always; 1: ready 1,0,0,1 repeating; 2: random ready.
    task automatic run_seq(input int kk, input int mode);
        logic [W-1:0] q[$];
        int n;
        int cyc;
        logic rdy;
        build_ref(kk, q);
        start = 1'b1;
        k_in  = 5'(kk);
        step();
        start = 1'b0;
        chk("seq_busy_on", 32'(busy), 1);
        n = 0;
        cyc = 0;
        while (n < q.size() && cyc < 4000) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            // Starts while busy must be ignored, whatever k they carry.
            start = 1'($urandom_range(0, 1));
            k_in  = 5'($urandom_range(0, 31));
            chk("seq_valid", 32'(out_valid), 1);
            chk("seq_pat",   32'(out_pattern), 32'(q[n]));
            chk("seq_idx",   32'(out_idx), 32'(n));
            chk("seq_last",  32'(out_last), 32'(n == q.size() - 1));
            chk("seq_err",   32'(err), 0);
            step();
            if (rdy) n++;
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("seq_count", 32'(n), 32'(q.size()));
        chk("seq_done_valid", 32'(out_valid), 0);
        chk("seq_done_busy",  32'(busy), 0);
        step();
        chk("seq_still_idle", 32'(busy), 0);
    endtask

    initial begin
        logic [W-1:0] q[$];

        // Reset state.
        #2;
        check_idle_reset_values("rst");
        step();
        check_idle_reset_values("rst_held");

        // Deassert and start right away: accepted on the first edge.
        rst_n = 1'b1;
        run_seq(2, 0);

        run_seq(0, 0);
        run_seq(8, 0);

        // k > W: single-cycle err, never valid.
        start = 1'b1;
        k_in  = 5'd9;
        step();
        start = 1'b0;
        chk("kbig_err", 32'(err), 1);
        chk("kbig_valid", 32'(out_valid), 0);
        chk("kbig_busy", 32'(busy), 0);
        step();
        chk("kbig_err_drop", 32'(err), 0);
        chk("kbig_valid2", 32'(out_valid), 0);

        run_seq(3, 1);

        for (int kk = 0; kk <= W; kk++) begin
            run_seq(kk, 2);
        end

        // Reset in the middle of a k=4 sequence at transfer 10.
        build_ref(4, q);
        start = 1'b1;
        k_in  = 5'd4;
        step();
        start = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("mid_pat", 32'(out_pattern), 32'(q[i]));
            step();
        end
        chk("mid_pat10", 32'(out_pattern), 32'(q[10]));
        rst_n = 1'b0;
        #1;
        check_idle_reset_values("mid_rst");
        step();
        check_idle_reset_values("mid_rst_held");
        rst_n = 1'b1;
        out_ready = 1'b0;
        run_seq(1, 0);

`ifdef WEIGHT_CHECK_EN
        chk("chk_clean", 32'(chk_err), 0);
        start = 1'b1;
        k_in  = 5'd3;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        force dut.out_pattern = 8'h0F;
        step();
        release dut.out_pattern;
        step();
        chk("chk_set", 32'(chk_err), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 200 && busy; i++) step();
        out_ready = 1'b0;
        chk("chk_done_busy", 32'(busy), 0);
        step();
        chk("chk_sticky", 32'(chk_err), 1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/weight_enum.md
WEIGHT_ENUM -- requirements
Module: weight_enum

Interface
REQ-001 SHALL have parameter W, default 8, pattern width; legal values are multiples of 4 from 4 to 16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port start  input  1  request to enumerate all W-bit patterns of weight k.
REQ-005 SHALL have port k  input  5  requested Hamming weight; sampled only when start is accepted.
REQ-006 SHALL have port out_ready  input  1  downstream ready for the current pattern.
REQ-007 SHALL have port out_valid  output  1  out_pattern holds a valid pattern.
REQ-008 SHALL have port out_pattern  output  W  current pattern, exactly k ones.
REQ-009 SHALL have port out_last  output  1  current pattern is the final one of the sequence.
REQ-010 SHALL have port out_idx  output  14  zero-based index of the current pattern.
REQ-011 SHALL have port busy  output  1  enumeration in progress.
REQ-012 SHALL have port err  output  1  one-cycle pulse when start is accepted with k > W.

Function
REQ-013 SHALL implement the states IDLE and EMIT; busy = (state == EMIT).
REQ-014 In IDLE, start with k <= W SHALL latch k, load pattern (1<<k)-1, clear out_idx, and enter EMIT; out_valid SHALL rise in the next cycle.
REQ-015 In IDLE, start with k > W SHALL pulse err for one cycle, remain in IDLE, and never assert out_valid.
REQ-016 start SHALL be ignored while busy; the latched k SHALL NOT change.
REQ-017 In EMIT, out_valid SHALL be 1; a transfer occurs on a cycle with out_valid && out_ready.
REQ-018 Without a transfer, out_pattern, out_last, and out_idx SHALL hold stable.
REQ-019 On a non-last transfer, the block SHALL load the lexicographic successor with the same weight in the next cycle and increment out_idx; throughput SHALL be one pattern per cycle.
REQ-020 The successor SHALL be computed as: c = x & -x; r = x + c; next = r | ((x ^ r) >> (tz(c)+2)), where tz is trailing-zero count and the arithmetic is W bits wide.
REQ-021 out_last SHALL be 1 when the pattern equals ((1<<k)-1) << (W-k), and for every k=0 or k=W pattern.
REQ-022 On a transfer with out_last = 1, the block SHALL return to IDLE in the next cycle with out_valid = 0; a start in that same cycle SHALL be ignored.
REQ-023 k=0 SHALL emit the single pattern 0 with out_last=1; k=W SHALL emit the single all-ones pattern with out_last=1.
REQ-024 The total number of transfers per sequence SHALL equal C(W,k), and out_idx of the final pattern SHALL be C(W,k)-1.

Reset
REQ-025 When rst_n = 0, the block SHALL immediately enter IDLE, including mid-sequence, with out_valid=0, out_pattern=0, out_last=0, out_idx=0, busy=0, err=0, and latched k=0.
REQ-026 After rst_n deassertion, the first start SHALL be honoured on the first rising clk edge.

Configuration
REQ-027 With macro WEIGHT_CHECK_EN defined, the block SHALL add output chk_err (1 bit, reset 0); chk_err SHALL be sticky-set when out_valid=1 and popcount(out_pattern) != latched k, and SHALL be cleared only by reset.
REQ-028 Without WEIGHT_CHECK_EN, the chk_err port and the popcount logic SHALL be absent.

Structure
REQ-029 A shared package weight_pkg SHALL hold the state enum type (IDLE, EMIT), localparam IDX_W=14, and MAX_W=16.
REQ-030 The checker SHALL use W/4 instances of sub-module popcnt_4 (4-bit in, 3-bit count out, combinational), summed; the sub-module SHALL be compiled only under WEIGHT_CHECK_EN.

Verification
REQ-031 W=8, k=2, out_ready=1: the bench SHALL see 0x03, 0x05, 0x06, 0x09 ..., ending at 0xC0, for 28 transfers, with out_last only on 0xC0 and out_idx 0..27.
REQ-032 W=8, k=0 -> one pattern 0x00 with out_last=1; k=8 -> one pattern 0xFF with out_last=1; then busy=0.
REQ-033 W=8, k=9 -> err high for exactly one cycle; out_valid stays 0; busy stays 0.
REQ-034 W=8, k=3 with out_ready toggled 1,0,0,1: the pattern SHALL hold at 0x0B during the stall, and all 56 patterns SHALL be delivered with no repeats or skips.
REQ-035 rst_n asserted low at transfer 10 of k=4 -> outputs go to reset values; a new start with k=1 SHALL then yield 0x01 through 0x80, 8 transfers.
REQ-036 With WEIGHT_CHECK_EN defined, all legal k for W=8 SHALL complete with chk_err=0; forcing one out_pattern bit via the bench SHALL make chk_err=1 and keep it set.
